bcd_seq_nxdisplay: RTL and testbench
====================================

// Module: bcd_seq_nxdisplay
// PURPOSE
//  Sequential binary-to-BCD converter (shift-and-add-3) driving DIGITS seven-segment displays.
//  Parametrised successor to the fixed 10-bit / 4-display combinational decoder.
//  Adds start/busy/done handshake, registered outputs held between conversions, and overflow detection.
//  Sits between a binary data source (switches, counter, ADC) and the board's display pins.
// PARAMETERS
//  WIDTH   10  width of binary input bin_in (1..20)
//  DIGITS  4   number of BCD digits / displays (1..8); digit 0 = units
// PORTS
//  clk      in   1           system clock, all logic on rising edge
//  rst      in   1           synchronous reset, active-high
//  start    in   1           conversion request, sampled only in IDLE
//  bin_in   in   WIDTH       unsigned binary value, captured on accepted start
//  busy     out  1           high while a conversion is in progress (SHIFT or DONE)
//  done     out  1           one-cycle pulse: result registers updated this cycle
//  overflow out  1           captured value > 10**DIGITS-1; held with result
//  bcd_out  out  4*DIGITS    packed BCD, digit i at [4*i+3:4*i]
//  seg_out  out  7*DIGITS    active-low segments {g,f,e,d,c,b,a}, digit i at [7*i+6:7*i]
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, overflow=0, bcd_out=0; seg_out all 1 (blank).
//  - rst dominates start. Reset mid-conversion aborts it: no done pulse, outputs return to reset values.
//  - FSM IDLE -> SHIFT -> DONE -> IDLE.
//    IDLE:  start=1 -> capture bin_in into shift reg, clear BCD scratch, cnt=WIDTH, go SHIFT.
//    SHIFT: per cycle, each scratch digit >=5 gets +3, then shift {scratch,bin} left 1; cnt--.
//           Once WIDTH shifts are complete -> DONE.
//    DONE:  load bcd_out, seg_out and overflow from scratch; done=1 for this cycle only; -> IDLE.
//  - Latency: start sampled at edge k -> done=1 and new outputs visible after edge k+WIDTH+1.
//  - busy=1 from edge k through the DONE cycle. Back-to-back: start held high restarts from the first IDLE cycle.
//  - start while busy is ignored, not queued. bin_in is sampled only at the accepting edge.
//  - Scratch is 4*DIGITS bits. Bits shifted out of the top digit are discarded.
//  - Overflow: at capture, compare against constant 10**DIGITS-1 (comparison width max(WIDTH,32)).
//    If overflow=1: bcd_out = all 4'hF; every digit shows "-" (7'b0111111).
//  - Segment map (active-low): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//    5=0010010 6=0000010 7=1111000 8=0000000 9=0010000.
//  - Outputs change only in the DONE cycle (or on reset); stable otherwise.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//    - In DONE, every digit above the most significant nonzero digit shows blank (7'b1111111).
//    - Digit 0 is never blanked, so value 0 shows a single "0".
//    - bcd_out is unaffected; blanking is skipped when overflow=1.
//  Not defined: all DIGITS displays show their digit, including leading zeros.
// TESTING
//  1 WIDTH=10,DIGITS=4: bin_in=1023, start pulse -> done after 11 cycles; bcd_out=16'h1023;
//    seg digits 3..0 = 1111001,1000000,0100100,0110000; overflow=0.
//  2 bin_in=0 -> bcd_out=16'h0000, all digits 1000000 (with _EN: digits 3..1 = 1111111, digit 0 = 1000000).
//  3 WIDTH=14,DIGITS=4: bin_in=10000 -> overflow=1, bcd_out=16'hFFFF, all digits 0111111;
//    bin_in=9999 -> overflow=0, bcd_out=16'h9999.
//  4 start with bin_in=500, then start with bin_in=7 three cycles later -> second ignored;
//    single done, bcd_out=16'h0500.
//  5 rst=1 mid-SHIFT (cycle 5) -> next cycle busy=0, done never pulses, seg_out all 1, bcd_out=0.
//  6 start held high for 3 conversions with bin_in=42 -> done every WIDTH+2 cycles, bcd_out=16'h0042.

Source files
------------

// File: rtl/bcd_seq_nxdisplay.sv
// bcd_seq_nxdisplay: sequential shift-and-add-3 binary-to-BCD converter
// driving DIGITS active-low seven-segment displays. A start/busy/done
// handshake is provided; the result registers hold between conversions.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
//
// state   | meaning
// S_IDLE  | waiting for start; outputs hold the last result
// S_SHIFT | one add-3 / shift step per cycle, WIDTH steps
// S_DONE  | result registers load at the end of this cycle
module bcd_seq_nxdisplay #(
   parameter int WIDTH  = 10,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin_in,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [7*DIGITS-1:0]   seg_out
);

   localparam int BW   = 4 * DIGITS;
   localparam int SW   = 7 * DIGITS;
   localparam int CW   = (WIDTH > 32) ? WIDTH : 32;
   localparam int CNTW = $clog2(WIDTH + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   function automatic logic [CW-1:0] max_value(input int n);
      longint r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return CW'(r - 1);
   endfunction

   localparam logic [CW-1:0] MAX_VAL = max_value(DIGITS);

   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 7'b1000000;
         4'd1:    seg7 = 7'b1111001;
         4'd2:    seg7 = 7'b0100100;
         4'd3:    seg7 = 7'b0110000;
         4'd4:    seg7 = 7'b0011001;
         4'd5:    seg7 = 7'b0010010;
         4'd6:    seg7 = 7'b0000010;
         4'd7:    seg7 = 7'b1111000;
         4'd8:    seg7 = 7'b0000000;
         4'd9:    seg7 = 7'b0010000;
         default: seg7 = SEG_BLANK;
      endcase
   endfunction

   logic [1:0]       state_q, state_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic [BW-1:0]    scr_q, scr_d;
   logic             ovf_pend_q, ovf_pend_d;
   logic             done_q, done_d;
   logic             ovf_q, ovf_d;
   logic [BW-1:0]    bcd_q, bcd_d;
   logic [SW-1:0]    seg_q, seg_d;
   logic [BW-1:0]    adj;

   // Next-state, datapath step and result formatting
   always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
      logic lead;
      lead       = 1'b1;
`endif
      state_d    = state_q;
      cnt_d      = cnt_q;
      bin_d      = bin_q;
      scr_d      = scr_q;
      ovf_pend_d = ovf_pend_q;
      done_d     = 1'b0;
      ovf_d      = ovf_q;
      bcd_d      = bcd_q;
      seg_d      = seg_q;
      adj        = scr_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (scr_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
      case (state_q)
         S_IDLE: begin
            if (start) begin
               bin_d      = bin_in;
               scr_d      = '0;
               cnt_d      = CNTW'(WIDTH);
               ovf_pend_d = (CW'(bin_in) > MAX_VAL);
               state_d    = S_SHIFT;
            end
         end
         S_SHIFT: begin
            // top-digit carry bits fall off the end of scratch
            scr_d = {adj[BW-2:0], bin_q[WIDTH-1]};
            bin_d = bin_q << 1;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNTW'(1)) state_d = S_DONE;
         end
         S_DONE: begin
            done_d  = 1'b1;
            ovf_d   = ovf_pend_q;
            state_d = S_IDLE;
            if (ovf_pend_q) begin
               bcd_d = '1;
               for (int i = 0; i < DIGITS; i++) seg_d[7*i +: 7] = SEG_DASH;
            end else begin
               bcd_d = scr_q;
               for (int i = 0; i < DIGITS; i++) seg_d[7*i +: 7] = seg7(scr_q[4*i +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
               // walk down from the top; digit 0 always shows
               for (int i = DIGITS - 1; i >= 1; i--) begin
                  if (scr_q[4*i +: 4] != 4'd0) lead = 1'b0;
                  if (lead) seg_d[7*i +: 7] = SEG_BLANK;
               end
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and result registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bin_q      <= '0;
         scr_q      <= '0;
         ovf_pend_q <= 1'b0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         bcd_q      <= '0;
         seg_q      <= '1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bin_q      <= bin_d;
         scr_q      <= scr_d;
         ovf_pend_q <= ovf_pend_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
         bcd_q      <= bcd_d;
         seg_q      <= seg_d;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign overflow = ovf_q;
   assign bcd_out  = bcd_q;
   assign seg_out  = seg_q;

endmodule

// File: tb/tb_bcd_seq_nxdisplay.sv
// Testbench for bcd_seq_nxdisplay: scoreboard of expected results, a
// monitor that checks each done pulse and output stability, and
// scenario tasks for latency, overflow, ignored start, abort, back-to-back.
module tb_bcd_seq_nxdisplay;

   localparam int W   = 10;
   localparam int W14 = 14;

   typedef struct packed {
      logic [15:0] bcd;
      logic [27:0] seg;
      logic        ovf;
   } exp_t;

   logic clk, rst;
   logic start, start14;
   logic [W-1:0]   bin_in;
   logic [W14-1:0] bin14;
   logic busy, done, overflow, busy14, done14, ovf14;
   logic [15:0] bcd_out, bcd14;
   logic [27:0] seg_out, seg14;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;
   int done_count = 0;
   bit mon_en  = 0;
   logic rst_seen = 1'b1;
   exp_t q[$];
   exp_t q14[$];
   exp_t held;

   logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000};

   bcd_seq_nxdisplay #(.WIDTH(W), .DIGITS(4)) dut (
      .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
      .busy(busy), .done(done), .overflow(overflow),
      .bcd_out(bcd_out), .seg_out(seg_out));

   bcd_seq_nxdisplay #(.WIDTH(W14), .DIGITS(4)) dut14 (
      .clk(clk), .rst(rst), .start(start14), .bin_in(bin14),
      .busy(busy14), .done(done14), .overflow(ovf14),
      .bcd_out(bcd14), .seg_out(seg14));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t m_exp(input int v);
      exp_t e;
      int   t;
      logic lead;
      e.ovf = (v > 9999);
      if (e.ovf) begin
         e.bcd = 16'hFFFF;
         e.seg = {4{7'b0111111}};
      end else begin
         t = v;
         for (int i = 0; i < 4; i++) begin
            e.bcd[4*i +: 4] = 4'(t % 10);
            e.seg[7*i +: 7] = seg_tab[t % 10];
            t = t / 10;
         end
`ifdef LEADING_ZERO_BLANK_EN
         lead = 1'b1;
         for (int i = 3; i >= 1; i--) begin
            if (e.bcd[4*i +: 4] != 4'd0) lead = 1'b0;
            if (lead) e.seg[7*i +: 7] = 7'b1111111;
         end
`else
         lead = 1'b0;
`endif
      end
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   always @(posedge clk) rst_seen <= rst;

   // Scoreboard / stability monitor for the WIDTH=10 instance
   always @(negedge clk) begin
      if (mon_en) begin
         exp_t e;
         vectors++;
         if (rst_seen) begin
            q.delete();
            held = '{bcd: 16'h0, seg: '1, ovf: 1'b0};
            if (done !== 1'b0 || busy !== 1'b0 || {bcd_out, seg_out, overflow} !== held) begin
               errors++;
               $display("FAIL reset_state: busy=%b done=%b bcd=%h seg=%h ovf=%b, need 0 0 0000 fffffff 0",
                        busy, done, bcd_out, seg_out, overflow);
            end
         end else if (done === 1'b1) begin
            done_count++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done: done pulse with no pending conversion, bcd=%h", bcd_out);
            end else begin
               e = q.pop_front();
               if ({bcd_out, seg_out, overflow} !== e) begin
                  errors++;
                  $display("FAIL result: bcd=%h seg=%b ovf=%b, need bcd=%h seg=%b ovf=%b",
                           bcd_out, seg_out, overflow, e.bcd, e.seg, e.ovf);
               end
               held = e;
            end
         end else if ({bcd_out, seg_out, overflow} !== held || done !== 1'b0) begin
            errors++;
            $display("FAIL hold: bcd=%h seg=%b ovf=%b done=%b, need bcd=%h seg=%b ovf=%b done=0",
                     bcd_out, seg_out, overflow, done, held.bcd, held.seg, held.ovf);
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; start14 = 1'b0; bin_in = '0; bin14 = '0;
      tick(); tick();
      mon_en = 1;
      vectors++;
      if (busy14 !== 1'b0 || done14 !== 1'b0 || bcd14 !== 16'h0 || seg14 !== '1 || ovf14 !== 1'b0) begin
         errors++;
         $display("FAIL reset_w14: busy=%b done=%b bcd=%h seg=%h ovf=%b, need 0 0 0000 fffffff 0",
                  busy14, done14, bcd14, seg14, ovf14);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_convert(input int v);
      int n;
      start = 1'b1; bin_in = W'(v);
      q.push_back(m_exp(v));
      tick();
      start = 1'b0; bin_in = W'(v ^ 'h2AA);
      vectors++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_after_start: busy=%b, need 1", busy);
      end
      n = 0;
      do begin tick(); n++; end while (done !== 1'b1 && n < 64);
      vectors++;
      if (n != W + 1) begin
         errors++;
         $display("FAIL latency(%0d): done after %0d edges, need %0d", v, n, W + 1);
      end
      tick();
      vectors++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_after_done: busy=%b, need 0", busy);
      end
   endtask

   task automatic test_overflow(input int v);
      int n;
      exp_t e;
      start14 = 1'b1; bin14 = W14'(v);
      q14.push_back(m_exp(v));
      tick();
      start14 = 1'b0; bin14 = '0;
      n = 0;
      do begin tick(); n++; end while (done14 !== 1'b1 && n < 64);
      vectors++;
      if (done14 !== 1'b1) begin
         errors++;
         $display("FAIL w14_timeout(%0d): no done within %0d edges", v, n);
         q14.delete();
      end else begin
         e = q14.pop_front();
         if (n != W14 + 1 || {bcd14, seg14, ovf14} !== e) begin
            errors++;
            $display("FAIL w14_result(%0d): n=%0d bcd=%h seg=%b ovf=%b, need n=%0d bcd=%h seg=%b ovf=%b",
                     v, n, bcd14, seg14, ovf14, W14 + 1, e.bcd, e.seg, e.ovf);
         end
      end
      tick();
   endtask

   task automatic test_ignore_busy();
      int n, dc;
      dc = done_count;
      start = 1'b1; bin_in = W'(500);
      q.push_back(m_exp(500));
      tick();
      start = 1'b0; bin_in = '0;
      tick(); tick();
      start = 1'b1; bin_in = W'(7);
      tick();
      start = 1'b0; bin_in = '0;
      n = 3;
      do begin tick(); n++; end while (done !== 1'b1 && n < 64);
      vectors++;
      if (n != W + 1) begin
         errors++;
         $display("FAIL ignore_latency: done after %0d edges, need %0d", n, W + 1);
      end
      repeat (2 * W) tick();
      vectors++;
      if (done_count - dc != 1) begin
         errors++;
         $display("FAIL ignore_single_done: %0d done pulses, need 1", done_count - dc);
      end
   endtask

   task automatic test_abort();
      int dc;
      start = 1'b1; bin_in = W'(777);
      q.push_back(m_exp(777));
      tick();
      start = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 16'h0 || seg_out !== '1) begin
         errors++;
         $display("FAIL abort_state: busy=%b done=%b bcd=%h seg=%h, need 0 0 0000 fffffff",
                  busy, done, bcd_out, seg_out);
      end
      dc = done_count;
      repeat (2 * W) tick();
      vectors++;
      if (done_count != dc) begin
         errors++;
         $display("FAIL abort_no_done: %0d done pulses, need 0", done_count - dc);
      end
   endtask

   task automatic test_back_to_back();
      int n, last, t;
      for (int i = 0; i < 3; i++) q.push_back(m_exp(42));
      start = 1'b1; bin_in = W'(42);
      tick();
      last = cyc - 1;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         do begin tick(); n++; end while (done !== 1'b1 && n < 64);
         if (k == 2) start = 1'b0;
         t = cyc - last;
         vectors++;
         if (done !== 1'b1 || t != W + 2) begin
            errors++;
            $display("FAIL back_to_back[%0d]: done=%b period=%0d, need done=1 period=%0d",
                     k, done, t, W + 2);
         end
         last = cyc;
      end
      start = 1'b0;
      repeat (2 * W) tick();
      vectors++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL back_to_back_drain: %0d results never produced, need 0", q.size());
      end
   endtask

   initial begin
      test_reset();
      test_convert(1023);
      test_convert(0);
      test_convert(999);
      test_convert(7);
      test_convert(560);
      test_overflow(10000);
      test_overflow(9999);
      test_overflow(16383);
      test_overflow(305);
      test_ignore_busy();
      test_abort();
      test_back_to_back();
      vectors++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL pending_results: %0d left in scoreboard, need 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
